// File: rtl/home_pkg.sv
// -----------------------------------------------------------------------------
// home_pkg
// Shared types for the keypad passcode sequencer.
//   seq_state_t : sequencer FSM states (IDLE, ENTRY, EVAL, LOCK)
//   digit_t     : one 4-bit keypad / stored-code digit
//   idx_t       : 2-bit digit index into the stored code
//   digit_match : modulo-16 subtract-and-test-zero digit comparator
// -----------------------------------------------------------------------------
package home_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_EVAL  = 2'd2,
      ST_LOCK  = 2'd3
   } seq_state_t;

   typedef logic [3:0] digit_t;
   typedef logic [1:0] idx_t;

   // Width of the lockout down-counter.
   localparam int LOCK_CNT_W = 16;

   // Match when (a - b) mod 16 is zero; the carry out is dropped on purpose.
   function automatic logic digit_match(input digit_t a, input digit_t b);
      digit_t w_diff;
      w_diff = a + ~b + 4'd1;
      return (w_diff == 4'd0);
   endfunction

endpackage

// File: rtl/pass_lock_timer.sv
// -----------------------------------------------------------------------------
// pass_lock_timer
// Lockout down-counter. Loading sets the count; it then decrements to zero.
// expired is high during the last counted cycle, i.e. the cycle whose clock
// edge takes the count from 1 to 0.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous, active-high; clears the count
//   load    : load cycles into the counter on the next edge
//   cycles  : lockout length in clk cycles
//   expired : count is 1 and about to reach 0
// -----------------------------------------------------------------------------
module pass_lock_timer
   import home_pkg::*;
#(
   parameter int W = LOCK_CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] cycles,
   output logic         expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= cycles;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign expired = (r_cnt == W'(1));

endmodule

// File: rtl/pass_sequencer.sv
// -----------------------------------------------------------------------------
// pass_sequencer
// Keypad passcode checker. Digits are accepted with a valid/ready handshake
// and compared one at a time against a stored code read from an external
// combinational ROM. A correct code pulses grant, a wrong one pulses fail;
// MAX_TRIES consecutive failures lock the keypad out for LOCK_CYCLES cycles.
//
// Handshake: a digit transfers on a rising edge where key_valid and key_ready
// are both 1 and abort is 0; key_valid may be held or dropped freely otherwise.
//
// Optional feature: define PASS_SEQ_TIMEOUT_EN to fail an entry that sits in
// ENTRY for TIMEOUT_CYCLES cycles without a handshake.
//
// Ports:
//   clk, reset           : clock; synchronous active-high reset
//   key_valid, key_data  : offered digit
//   key_ready            : digit can be accepted this cycle
//   abort                : discard the partial entry (IDLE/ENTRY only)
//   rom_addr, rom_data   : stored-code index and its digit
//   grant, fail          : one-cycle result pulses
//   alarm                : high for the whole lockout
//   attempts             : consecutive failed entries
//   o_dbg_state          : current FSM state, for debug/checkers
// -----------------------------------------------------------------------------
module pass_sequencer
   import home_pkg::*;
#(
   parameter int CODE_LEN       = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCK_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_data,
   output logic       key_ready,
   input  logic       abort,
   output logic [1:0] rom_addr,
   input  logic [3:0] rom_data,
   output logic       grant,
   output logic       fail,
   output logic       alarm,
   output logic [1:0] attempts,
   output logic [1:0] o_dbg_state
);

   // Elaboration-time parameter legality.
   if (CODE_LEN < 1 || CODE_LEN > 4)  begin : g_bad_code_len  $error("CODE_LEN out of range");  end
   if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_max_tries $error("MAX_TRIES out of range"); end
   if (LOCK_CYCLES < 1)                begin : g_bad_lock      $error("LOCK_CYCLES below 1");     end
   if (TIMEOUT_CYCLES < 1)             begin : g_bad_timeout   $error("TIMEOUT_CYCLES below 1");  end

   localparam idx_t LAST_IDX = idx_t'(CODE_LEN - 1);
   localparam idx_t MAX_ATT  = idx_t'(MAX_TRIES);

   seq_state_t r_state, w_state_nxt;
   idx_t       r_idx, w_idx_nxt;
   logic       r_mis, w_mis_nxt;
   idx_t       r_att, w_att_nxt;

   logic w_open, w_hs, w_match, w_load, w_expired, w_grant, w_fail;

   // Ready is withheld during reset so nothing is offered a handshake then.
   assign w_open    = (r_state == ST_IDLE) || (r_state == ST_ENTRY);
   assign key_ready = w_open && !reset;
   assign w_hs      = key_valid && key_ready && !abort;
   assign w_match   = digit_match(key_data, rom_data);

`ifdef PASS_SEQ_TIMEOUT_EN
   logic [15:0] r_to;
   logic        w_to_hit;

   // Counts ENTRY cycles with no handshake; restarts on every digit.
   always_ff @(posedge clk) begin
      if (reset || r_state != ST_ENTRY || w_hs || abort) begin
         r_to <= '0;
      end else begin
         r_to <= r_to + 16'd1;
      end
   end

   assign w_to_hit = (r_state == ST_ENTRY) && !w_hs && !abort &&
                     (r_to == 16'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_mis   <= 1'b0;
         r_att   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_mis   <= w_mis_nxt;
         r_att   <= w_att_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_mis_nxt   = r_mis;
      w_att_nxt   = r_att;
      w_load      = 1'b0;
      w_grant     = 1'b0;
      w_fail      = 1'b0;
      case (r_state)
         ST_IDLE, ST_ENTRY: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
               w_mis_nxt   = 1'b0;
            end else if (w_hs) begin
               // Sticky: one wrong digit spoils the whole entry.
               w_mis_nxt = r_mis || !w_match;
               if (r_idx == LAST_IDX) begin
                  w_state_nxt = ST_EVAL;
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = ST_ENTRY;
                  w_idx_nxt   = r_idx + 2'd1;
               end
            end
`ifdef PASS_SEQ_TIMEOUT_EN
            else if (w_to_hit) begin
               w_state_nxt = ST_EVAL;
               w_idx_nxt   = '0;
               w_mis_nxt   = 1'b1;
            end
`endif
         end
         ST_EVAL: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_mis_nxt   = 1'b0;
            if (!r_mis) begin
               w_grant   = 1'b1;
               w_att_nxt = '0;
            end else begin
               w_fail = 1'b1;
               // Saturate at MAX_TRIES and lock out instead of wrapping.
               if (r_att >= MAX_ATT - 2'd1) begin
                  w_att_nxt   = MAX_ATT;
                  w_state_nxt = ST_LOCK;
                  w_load      = 1'b1;
               end else begin
                  w_att_nxt = r_att + 2'd1;
               end
            end
         end
         ST_LOCK: begin
            if (w_expired) begin
               w_state_nxt = ST_IDLE;
               w_att_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   pass_lock_timer #(.W(LOCK_CNT_W)) u_lock_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (w_load),
      .cycles  (LOCK_CNT_W'(LOCK_CYCLES)),
      .expired (w_expired)
   );

   // Outputs are masked by reset so an abandoned EVAL or LOCK shows nothing.
   assign grant       = w_grant && !reset;
   assign fail        = w_fail && !reset;
   assign alarm       = (r_state == ST_LOCK) && !reset;
   assign rom_addr    = r_idx;
   assign attempts    = r_att;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pass_sequencer.sv
module tb_pass_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_data;
  logic       key_ready;
  logic       abort;
  logic [1:0] rom_addr;
  logic [3:0] rom_data;
  logic       grant;
  logic       fail;
  logic       alarm;
  logic [1:0] attempts;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [3:0] rom [4];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    rom[0] = 4'd3;
    rom[1] = 4'd7;
    rom[2] = 4'd1;
    rom[3] = 4'd9;
  end

  assign rom_data = rom[rom_addr];

  pass_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_data    (key_data),
    .key_ready   (key_ready),
    .abort       (abort),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .grant       (grant),
    .fail        (fail),
    .alarm       (alarm),
    .attempts    (attempts),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // driver: four digits back-to-back, checking ready and ROM index per digit
  task automatic send_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_data  = code[15-4*i -: 4];
      total++;
      if (key_ready !== 1'b1) begin
        bad++;
        $display("FAIL digit_ready[%0d]: got %b want 1", i, key_ready);
      end
      total++;
      if (rom_addr !== 2'(i)) begin
        bad++;
        $display("FAIL digit_rom_addr[%0d]: got %0d want %0d", i, rom_addr, i);
      end
      step();
      key_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; key_valid = 1'b0; key_data = 4'd0; abort = 1'b0;
    step(); step();
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", key_ready); end
    total++; if (grant !== 1'b0)     begin bad++; $display("FAIL reset_grant: got %b want 0", grant); end
    total++; if (fail !== 1'b0)      begin bad++; $display("FAIL reset_fail: got %b want 0", fail); end
    total++; if (alarm !== 1'b0)     begin bad++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    total++; if (attempts !== 2'd0)  begin bad++; $display("FAIL reset_attempts: got %0d want 0", attempts); end
    total++; if (rom_addr !== 2'd0)  begin bad++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    reset = 1'b0;
    step();
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", key_ready); end
  endtask

  task automatic test_grant;
    send_code(16'h3719);
    total++; if (grant !== 1'b1)     begin bad++; $display("FAIL grant_pulse: got %b want 1", grant); end
    total++; if (fail !== 1'b0)      begin bad++; $display("FAIL grant_nofail: got %b want 0", fail); end
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL grant_eval_ready: got %b want 0", key_ready); end
    step();
    total++; if (grant !== 1'b0)     begin bad++; $display("FAIL grant_one_cycle: got %b want 0", grant); end
    total++; if (attempts !== 2'd0)  begin bad++; $display("FAIL grant_attempts: got %0d want 0", attempts); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL grant_idle_ready: got %b want 1", key_ready); end
  endtask

  task automatic test_fail;
    send_code(16'h3729);
    total++; if (fail !== 1'b1)      begin bad++; $display("FAIL fail_pulse: got %b want 1", fail); end
    total++; if (grant !== 1'b0)     begin bad++; $display("FAIL fail_nogrant: got %b want 0", grant); end
    step();
    total++; if (fail !== 1'b0)      begin bad++; $display("FAIL fail_one_cycle: got %b want 0", fail); end
    total++; if (attempts !== 2'd1)  begin bad++; $display("FAIL fail_attempts: got %0d want 1", attempts); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL fail_next_ready: got %b want 1", key_ready); end
  endtask

  // expects attempts == 1 on entry
  task automatic test_abort;
    key_valid = 1'b1; key_data = 4'd3;
    step();
    total++; if (rom_addr !== 2'd1) begin bad++; $display("FAIL abort_first_digit: got %0d want 1", rom_addr); end
    key_data = 4'd7; abort = 1'b1;
    step();
    abort = 1'b0; key_valid = 1'b0;
    total++; if (rom_addr !== 2'd0)  begin bad++; $display("FAIL abort_idx_clear: got %0d want 0", rom_addr); end
    total++; if (attempts !== 2'd1)  begin bad++; $display("FAIL abort_attempts: got %0d want 1", attempts); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", key_ready); end
    send_code(16'h3719);
    total++; if (grant !== 1'b1)     begin bad++; $display("FAIL abort_then_grant: got %b want 1", grant); end
    step();
    total++; if (attempts !== 2'd0)  begin bad++; $display("FAIL abort_grant_attempts: got %0d want 0", attempts); end
  endtask

  // three wrong codes from attempts == 0; leaves the bench in lock cycle 1
  task automatic enter_lock(input string tag);
    for (int k = 0; k < 3; k++) begin
      send_code(16'h3729);
      total++; if (fail !== 1'b1) begin bad++; $display("FAIL %s_fail[%0d]: got %b want 1", tag, k, fail); end
      step();
      total++;
      if (attempts !== 2'(k + 1)) begin
        bad++; $display("FAIL %s_attempts[%0d]: got %0d want %0d", tag, k, attempts, k + 1);
      end
    end
  endtask

  task automatic test_lockout;
    int n;
    int ready_bad;
    enter_lock("lock");
    n = 0; ready_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (!alarm) break;
      n++;
      if (key_ready !== 1'b0) ready_bad++;
      step();
    end
    total++; if (n != 16)           begin bad++; $display("FAIL lock_alarm_len: got %0d want 16", n); end
    total++; if (ready_bad != 0)    begin bad++; $display("FAIL lock_ready_low: got %0d high cycles want 0", ready_bad); end
    total++; if (attempts !== 2'd0) begin bad++; $display("FAIL lock_exit_attempts: got %0d want 0", attempts); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL lock_exit_ready: got %b want 1", key_ready); end
  endtask

  task automatic test_reset_in_lock;
    int pulses;
    enter_lock("rlock");
    for (int c = 0; c < 4; c++) step();
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL rlock_cycle5_alarm: got %b want 1", alarm); end
    reset = 1'b1;
    #1;
    total++; if (alarm !== 1'b0)     begin bad++; $display("FAIL rlock_rst_alarm: got %b want 0", alarm); end
    total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL rlock_rst_ready: got %b want 0", key_ready); end
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if (alarm !== 1'b0 || key_ready !== 1'b0) begin
        bad++; $display("FAIL rlock_rst_hold[%0d]: got alarm=%b ready=%b want 0 0", c, alarm, key_ready);
      end
      if (grant || fail) pulses++;
    end
    reset = 1'b0;
    step();
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL rlock_release_ready: got %b want 1", key_ready); end
    total++; if (attempts !== 2'd0)  begin bad++; $display("FAIL rlock_release_attempts: got %0d want 0", attempts); end
    for (int c = 0; c < 20; c++) begin
      if (grant || fail || alarm) pulses++;
      step();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rlock_no_pulse: got %0d pulses want 0", pulses); end
  endtask

`ifdef PASS_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    key_valid = 1'b1; key_data = 4'd3;
    step();
    key_valid = 1'b0;
    n = 0;
    while (!fail && n < 100) begin
      step();
      n++;
    end
    total++; if (n != 64)          begin bad++; $display("FAIL timeout_cycles: got %0d want 64", n); end
    total++; if (fail !== 1'b1)    begin bad++; $display("FAIL timeout_fail: got %b want 1", fail); end
    step();
    total++; if (attempts !== 2'd1) begin bad++; $display("FAIL timeout_attempts: got %0d want 1", attempts); end
  endtask
`endif

  initial begin
    test_reset();
    test_grant();
    test_fail();
    test_abort();
    test_lockout();
    test_reset_in_lock();
`ifdef PASS_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pass_sequencer.md
PASS_SEQUENCER -- requirements
Module: pass_sequencer

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4: digits per code, legal range 1..4.
REQ-002 SHALL have parameter MAX_TRIES, default 3: failed entries before lockout, legal range 1..3.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: lockout duration in clk cycles, must be at least 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64: inter-digit timeout, used only when PASS_SEQ_TIMEOUT_EN is defined.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port key_valid, input, 1 bit: a digit is offered.
REQ-008 SHALL have port key_data, input, 4 bits: the offered digit.
REQ-009 SHALL have port key_ready, output, 1 bit: the sequencer accepts a digit this cycle.
REQ-010 SHALL have port abort, input, 1 bit: discard the partial entry.
REQ-011 SHALL have port rom_addr, output, 2 bits: stored-code digit index.
REQ-012 SHALL have port rom_data, input, 4 bits: stored digit, combinational from rom_addr.
REQ-013 SHALL have port grant, output, 1 bit: one-cycle pulse on a correct code.
REQ-014 SHALL have port fail, output, 1 bit: one-cycle pulse on a wrong code.
REQ-015 SHALL have port alarm, output, 1 bit: high for the whole lockout.
REQ-016 SHALL have port attempts, output, 2 bits: consecutive failed entries.

Function
REQ-017 SHALL implement states IDLE, ENTRY, EVAL and LOCK.
REQ-018 SHALL hold key_ready at 1 in IDLE and ENTRY, and at 0 in EVAL and LOCK.
REQ-019 SHALL accept a digit only on a cycle where key_valid and key_ready are both 1, then increment the digit index (idx) and latch a sticky mismatch flag.
REQ-020 SHALL drive rom_addr equal to idx as a registered value, and compare key_data with rom_data in the same cycle.
REQ-021 SHALL compute a match as (key_data + ~rom_data + 1) mod 16 == 0, with the 4-bit result and the carry discarded.
REQ-022 SHALL move from IDLE to ENTRY on the first accepted digit, and to EVAL on the cycle the CODE_LEN-th digit is accepted.
REQ-023 SHALL spend exactly one cycle in EVAL.
REQ-024 SHALL, in EVAL with no mismatch: pulse grant, clear attempts, and go to IDLE.
REQ-025 SHALL, in EVAL with a mismatch: pulse fail and increment attempts; go to LOCK when attempts reaches MAX_TRIES, otherwise go to IDLE.
REQ-026 SHALL produce a grant or fail pulse 1 cycle after the final digit's handshake.
REQ-027 SHALL, on entering LOCK, load a counter with LOCK_CYCLES and hold alarm at 1 while in LOCK.
REQ-028 SHALL, when the LOCK counter reaches 0, clear attempts and alarm and go to IDLE, so that alarm is high for exactly LOCK_CYCLES cycles.
REQ-029 SHALL, on abort in IDLE or ENTRY, clear idx and the mismatch flag, leave attempts unchanged, and go to IDLE.
REQ-030 SHALL give abort priority over a digit handshake in the same cycle, dropping that digit.
REQ-031 SHALL ignore abort in EVAL and in LOCK.
REQ-032 SHALL never let attempts wrap past MAX_TRIES.
REQ-033 SHALL clear idx on every exit from ENTRY or EVAL.

Reset
REQ-034 SHALL, on a synchronous reset, force: state=IDLE, idx=0, rom_addr=0, mismatch=0, attempts=0, grant=0, fail=0, alarm=0, lock counter=0.
REQ-035 SHALL abandon any in-progress entry or lockout when reset is asserted, with no grant or fail pulse.
REQ-036 SHALL drive key_ready=0 while reset is high and key_ready=1 on the cycle after reset is released.

Configuration
REQ-037 SHALL, with PASS_SEQ_TIMEOUT_EN defined, count cycles in ENTRY without a handshake.
REQ-038 SHALL, with PASS_SEQ_TIMEOUT_EN defined, treat a count reaching TIMEOUT_CYCLES exactly as a mismatched EVAL: fail pulse and attempts increment.
REQ-039 SHALL, without PASS_SEQ_TIMEOUT_EN, wait in ENTRY indefinitely and contain no timeout logic.

Structure
REQ-040 SHALL take the state enum, the 4-bit digit type and a 2-bit index type from the shared package home_pkg.
REQ-041 SHALL place the LOCK down-counter in one sub-module, pass_lock_timer, with inputs load and cycles and output expired.

Verification (bench ROM contents 3,7,1,9; default parameters)
REQ-042 SHALL be checked with: digits 3,7,1,9 back-to-back -> grant=1 one cycle after the 4th handshake, attempts=0.
REQ-043 SHALL be checked with: digits 3,7,2,9 -> fail pulse, attempts=1, key_ready=1 on the next cycle.
REQ-044 SHALL be checked with: three wrong codes -> alarm high for exactly 16 cycles, key_ready=0 throughout, then attempts=0.
REQ-045 SHALL be checked with: abort together with key_valid on digit 2, then digits 3,7,1,9 -> grant, attempts unchanged.
REQ-046 SHALL be checked with: reset at cycle 5 of LOCK -> alarm=0 and key_ready=0 while reset is high, key_ready=1 on the cycle after reset is released, no pulse on either output.
REQ-047 SHALL be checked, with PASS_SEQ_TIMEOUT_EN defined, with: one digit then 64 idle cycles -> fail pulse, attempts=1.
